// File: rtl/stopwatch_cu.sv
// Stopwatch control unit: debounces three raw button levels, sequences STOP/RUN/LAP/CLEAR,
// and selects between the live time and a latched lap snapshot for the display.
module stopwatch_cu #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_run_stop,
  input  logic       btn_clear,
  input  logic       btn_lap,
  input  logic [6:0] i_msec,
  input  logic [5:0] i_sec,
  input  logic [5:0] i_min,
  input  logic [4:0] i_hour,
  output logic       run_stop,
  output logic       clear,
  output logic       lap_active,
  output logic [6:0] disp_msec,
  output logic [5:0] disp_sec,
  output logic [5:0] disp_min,
  output logic [4:0] disp_hour
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Bit order: 0 = run/stop, 1 = clear, 2 = lap.
  logic [2:0] btn_raw;
  logic [2:0] press;

  assign btn_raw = {btn_lap, btn_clear, btn_run_stop};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
      logic          sync1_reg;
      logic          sync2_reg;
      logic          deb_reg;
      logic          deb_d_reg;
      logic          press_reg;
      logic [CW-1:0] cnt_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
          deb_reg   <= 1'b0;
          deb_d_reg <= 1'b0;
          press_reg <= 1'b0;
          cnt_reg   <= '0;
        end else begin
          sync1_reg <= btn_raw[gi];
          sync2_reg <= sync1_reg;
          deb_d_reg <= deb_reg;
          press_reg <= deb_reg & ~deb_d_reg;
          // The counter holds the number of differing cycles already seen, so the
          // DEBOUNCE_CYCLES-th one is the cycle where it reads CNT_LAST.
          if (sync2_reg == deb_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            deb_reg <= sync2_reg;
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign press[gi] = press_reg;
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_LAP   = 2'd2,
    ST_CLEAR = 2'd3
  } state_t;

  state_t     state_reg;
  state_t     state_next;
  logic       run_stop_reg;
  logic       clear_reg;
  logic       lap_active_reg;
  logic [6:0] lap_msec_reg;
  logic [5:0] lap_sec_reg;
  logic [5:0] lap_min_reg;
  logic [4:0] lap_hour_reg;

  // Priority run > clear > lap; an illegal higher-priority press does not block a legal lower one.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_STOP: begin
        if (press[0])      state_next = ST_RUN;
        else if (press[1]) state_next = ST_CLEAR;
      end
      ST_RUN: begin
        if (press[0])      state_next = ST_STOP;
        else if (press[2]) state_next = ST_LAP;
      end
      ST_LAP: begin
        if (press[0])      state_next = ST_STOP;
        else if (press[2]) state_next = ST_RUN;
      end
      ST_CLEAR: state_next = ST_STOP;
      default:  state_next = ST_STOP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_STOP;
      run_stop_reg   <= 1'b0;
      clear_reg      <= 1'b0;
      lap_active_reg <= 1'b0;
      lap_msec_reg   <= '0;
      lap_sec_reg    <= '0;
      lap_min_reg    <= '0;
      lap_hour_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      run_stop_reg   <= (state_next == ST_RUN) || (state_next == ST_LAP);
      clear_reg      <= (state_next == ST_CLEAR);
      lap_active_reg <= (state_next == ST_LAP);
      if ((state_reg == ST_RUN) && (state_next == ST_LAP)) begin
        lap_msec_reg <= i_msec;
        lap_sec_reg  <= i_sec;
        lap_min_reg  <= i_min;
        lap_hour_reg <= i_hour;
      end
    end
  end

  assign run_stop   = run_stop_reg;
  assign clear      = clear_reg;
  assign lap_active = lap_active_reg;

  assign disp_msec = lap_active_reg ? lap_msec_reg : i_msec;
  assign disp_sec  = lap_active_reg ? lap_sec_reg  : i_sec;
  assign disp_min  = lap_active_reg ? lap_min_reg  : i_min;
  assign disp_hour = lap_active_reg ? lap_hour_reg : i_hour;

endmodule

// File: tb/tb_stopwatch_cu.sv
// Directed bench for stopwatch_cu with a short debounce window; inputs driven and
// outputs sampled on the falling edge.
module tb_stopwatch_cu;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_run_stop;
  logic       btn_clear;
  logic       btn_lap;
  logic [6:0] i_msec;
  logic [5:0] i_sec;
  logic [5:0] i_min;
  logic [4:0] i_hour;
  logic       run_stop;
  logic       clear;
  logic       lap_active;
  logic [6:0] disp_msec;
  logic [5:0] disp_sec;
  logic [5:0] disp_min;
  logic [4:0] disp_hour;

  int tests  = 0;
  int failed = 0;
  logic seen;

  stopwatch_cu #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .btn_run_stop(btn_run_stop), .btn_clear(btn_clear), .btn_lap(btn_lap),
    .i_msec(i_msec), .i_sec(i_sec), .i_min(i_min), .i_hour(i_hour),
    .run_stop(run_stop), .clear(clear), .lap_active(lap_active),
    .disp_msec(disp_msec), .disp_sec(disp_sec), .disp_min(disp_min), .disp_hour(disp_hour)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Full press: hold well past the debounce window, then release and let it settle.
  task automatic press_btn(input int idx);
    case (idx)
      0: btn_run_stop = 1'b1;
      1: btn_clear    = 1'b1;
      default: btn_lap = 1'b1;
    endcase
    cyc(10);
    btn_run_stop = 1'b0;
    btn_clear    = 1'b0;
    btn_lap      = 1'b0;
    cyc(10);
    $display("[TB] press btn %0d -> run_stop=%0b clear=%0b lap_active=%0b", idx, run_stop, clear, lap_active);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    btn_run_stop = 1'b0; btn_clear = 1'b0; btn_lap = 1'b0;
    i_msec = 7'd0; i_sec = 6'd0; i_min = 6'd0; i_hour = 5'd0;
    cyc(3);
    chk("reset_run_stop", run_stop, 0);
    chk("reset_clear", clear, 0);
    chk("reset_lap_active", lap_active, 0);

    // Release reset and raise run/stop; the next rising edge is edge 1.
    rst = 1'b0;
    btn_run_stop = 1'b1;
    cyc(7);
    chk("run_latency_edge7", run_stop, 0);
    cyc(1);
    chk("run_latency_edge8", run_stop, 1);
    cyc(50);
    chk("run_hold_run_stop", run_stop, 1);
    chk("run_hold_clear", clear, 0);
    chk("run_hold_lap", lap_active, 0);
    btn_run_stop = 1'b0;
    cyc(10);
    chk("run_release", run_stop, 1);
    $display("[TB] held run press -> run_stop=%0b", run_stop);

    // Glitch shorter than the window.
    btn_run_stop = 1'b1;
    cyc(3);
    btn_run_stop = 1'b0;
    cyc(12);
    chk("glitch_ignored", run_stop, 1);
    $display("[TB] 3-cycle glitch -> run_stop=%0b", run_stop);
    press_btn(0);
    chk("run_to_stop", run_stop, 0);

    // Clear from STOP: exactly one cycle high.
    btn_clear = 1'b1;
    cyc(7);
    chk("clear_edge7", clear, 0);
    cyc(1);
    chk("clear_edge8", clear, 1);
    chk("clear_run_stop", run_stop, 0);
    cyc(1);
    chk("clear_edge9", clear, 0);
    btn_clear = 1'b0;
    cyc(10);
    chk("clear_back_stop", run_stop, 0);
    $display("[TB] clear in STOP -> one-cycle pulse");

    // Clear ignored in RUN.
    press_btn(0);
    chk("run_again", run_stop, 1);
    seen = 1'b0;
    btn_clear = 1'b1;
    for (int i = 0; i < 10; i++) begin cyc(1); seen = seen | clear; end
    btn_clear = 1'b0;
    for (int i = 0; i < 10; i++) begin cyc(1); seen = seen | clear; end
    chk("clear_in_run_ignored", seen, 0);
    chk("clear_in_run_state", run_stop, 1);
    $display("[TB] clear in RUN -> clear_seen=%0b", seen);

    // Lap snapshot.
    i_msec = 7'd34; i_sec = 6'd12; i_min = 6'd5; i_hour = 5'd2;
    btn_lap = 1'b1;
    cyc(8);
    chk("lap_enter", lap_active, 1);
    chk("lap_run_stop", run_stop, 1);
    i_msec = 7'd35; i_sec = 6'd13; i_min = 6'd6; i_hour = 5'd3;
    #1;
    chk("lap_disp_msec", disp_msec, 34);
    chk("lap_disp_sec", disp_sec, 12);
    chk("lap_disp_min", disp_min, 5);
    chk("lap_disp_hour", disp_hour, 2);
    btn_lap = 1'b0;
    cyc(10);
    i_sec = 6'd14;
    #1;
    chk("lap_frozen", disp_sec, 12);
    $display("[TB] lap press -> disp %0d:%0d held", disp_sec, disp_msec);
    press_btn(2);
    chk("lap_exit", lap_active, 0);
    chk("lap_exit_run", run_stop, 1);
    i_sec = 6'd20;
    #1;
    chk("live_disp_sec", disp_sec, 20);
    chk("live_disp_msec", disp_msec, 35);

    // Run and lap pulses coincide in RUN: run wins, lap is discarded.
    btn_run_stop = 1'b1;
    btn_lap = 1'b1;
    cyc(8);
    chk("coinc_run_stop", run_stop, 0);
    chk("coinc_lap", lap_active, 0);
    btn_run_stop = 1'b0;
    btn_lap = 1'b0;
    cyc(10);
    chk("coinc_settled_run", run_stop, 0);
    chk("coinc_settled_lap", lap_active, 0);
    $display("[TB] run+lap coincident -> run_stop=%0b lap_active=%0b", run_stop, lap_active);

    // Run press from LAP returns to STOP.
    press_btn(0);
    press_btn(2);
    chk("lap2_enter", lap_active, 1);
    i_sec = 6'd21;
    #1;
    chk("lap2_disp_sec", disp_sec, 20);
    press_btn(0);
    chk("lap_to_stop_run", run_stop, 0);
    chk("lap_to_stop_lap", lap_active, 0);
    #1;
    chk("lap_to_stop_disp", disp_sec, 21);

    // Async reset in LAP with clear partly debounced.
    press_btn(0);
    press_btn(2);
    chk("lap3_enter", lap_active, 1);
    btn_clear = 1'b1;
    cyc(5);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_run_stop", run_stop, 0);
    chk("rst_async_clear", clear, 0);
    chk("rst_async_lap", lap_active, 0);
    btn_clear = 1'b0;
    cyc(2);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin cyc(1); seen = seen | clear | run_stop | lap_active; end
    chk("rst_no_followup", seen, 0);
    $display("[TB] reset in LAP -> outputs idle, activity_seen=%0b", seen);
    press_btn(0);
    chk("post_rst_run", run_stop, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/stopwatch_cu.md
Name: stopwatch_cu

Overview:
Control unit for the stopwatch datapath. It debounces three raw push-button levels and runs the STOP/RUN/LAP/CLEAR state machine. It drives the datapath's run_stop and clear inputs, and it multiplexes the display between the live time and a latched lap snapshot. It sits between the board buttons and stopwatch_dp, and its display outputs feed the FND/display driver.

Parameters:
DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles required to accept a button level change (10 ms at 100 MHz); legal range >= 2.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
btn_run_stop  input  1  raw run/stop button level, asynchronous to clk
btn_clear  input  1  raw clear button level, asynchronous to clk
btn_lap  input  1  raw lap button level, asynchronous to clk
i_msec  input  7  live msec count from the datapath
i_sec  input  6  live sec count from the datapath
i_min  input  6  live min count from the datapath
i_hour  input  5  live hour count from the datapath
run_stop  output  1  datapath enable; registered
clear  output  1  datapath clear pulse; registered
lap_active  output  1  high while the display is frozen on the lap snapshot; registered
disp_msec  output  7  display msec
disp_sec  output  6  display sec
disp_min  output  6  display min
disp_hour  output  5  display hour

Behaviour:
- Reset (async, immediate): state=STOP. run_stop=0, clear=0, lap_active=0. Lap registers=0. Sync flops=0. Debounced levels=0. Debounce counters=0. Press pulses=0. Reset mid-operation in any state returns to STOP with these values.
- Per-button front end (three identical instances):
  - 2-flop synchronizer.
  - Counter with width $clog2(DEBOUNCE_CYCLES) counts cycles where the synced level differs from the debounced level.
  - Counter clears to 0 on any cycle the levels agree.
  - On the DEBOUNCE_CYCLES-th consecutive differing cycle, the debounced level takes the synced value and the counter clears.
  - press pulse = registered rising edge of the debounced level: exactly 1 cycle per press. Release produces no pulse.
- Latency: counting the first clk edge that samples a raw level as edge 1, and with the raw level held stable:
  - debounced level updates at edge DEBOUNCE_CYCLES+2;
  - press pulse is high after edge DEBOUNCE_CYCLES+3;
  - FSM state and Moore outputs change at edge DEBOUNCE_CYCLES+4.
- A raw high shorter than DEBOUNCE_CYCLES synced cycles produces no pulse. Holding a button produces one pulse only.
- FSM, Moore outputs registered from next-state:
  - STOP (run_stop=0, clear=0, lap_active=0): run press -> RUN; clear press -> CLEAR; lap press ignored.
  - RUN (run_stop=1, lap_active=0): run press -> STOP; lap press -> LAP; clear press ignored.
  - LAP (run_stop=1, lap_active=1): lap press -> RUN; run press -> STOP (lap_active drops, display returns live); clear press ignored.
  - CLEAR (run_stop=0, clear=1): unconditional -> STOP next cycle, so clear is high exactly 1 cycle. All presses arriving in CLEAR are discarded.
- Simultaneous pulses in one cycle: priority run_stop > clear > lap. Only the highest-priority pulse that is legal in the current state acts; the others are discarded, not queued.
- Lap snapshot: on the edge that enters LAP from RUN, the lap registers capture i_msec/i_sec/i_min/i_hour as sampled at that edge. The registers hold until the next LAP entry or reset.
- Display mux (combinational): disp_* = lap_active ? lap registers : i_* (live pass-through). The datapath keeps counting while in LAP.

Test Plan:
- DEBOUNCE_CYCLES=4, release rst, raise btn_run_stop at edge 1 and hold -> run_stop=1 after edge 8; holding 50 more cycles causes no further transition.
- From RUN, 3-cycle btn_run_stop glitch -> no pulse, run_stop stays 1. Then a full press -> STOP, run_stop=0.
- In STOP, press btn_clear -> clear=1 for exactly one cycle, state STOP afterwards. btn_clear pressed in RUN -> clear stays 0.
- In RUN with i_sec=12, i_msec=34, press lap -> lap_active=1, disp_sec=12, disp_msec=34 held while i_* advances. Second lap press -> disp_* tracks i_* again.
- btn_run_stop and btn_lap debounced pulses coincide in RUN -> STOP, lap_active=0, lap registers unchanged.
- Assert rst while in LAP with clear pending in the debouncer -> all outputs 0 immediately. No clear pulse or state change follows until a new full press.
